// File: rtl/tts_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tts_pkg
// Description : Shared state encodings and sizing helpers for the truth-table
//               sweeper.
// Revision    : 1.0 - initial release
// ============================================================================
package tts_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    function automatic int num_vec(input int n);
        return 1 << n;
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // A counter holding SETTLE-1 still needs one bit when SETTLE is 1.
    function automatic int settle_width(input int settle);
        return (clog2(settle) < 1) ? 1 : clog2(settle);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tts_settle_timer.sv
`default_nettype none
// ============================================================================
// Module      : tts_settle_timer
// Description : Loadable down-counter from SETTLE-1 to 0; tc is high while
//               the count sits at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module tts_settle_timer
    import tts_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic tc
);

    localparam int               c_CNT_W = settle_width(SETTLE);
    localparam logic [c_CNT_W-1:0] c_LOAD = c_CNT_W'(SETTLE - 1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= c_LOAD;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_CNT_W'(1);
        end
    end

    assign tc = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_sweeper
// Description : Walks every input vector of an N_IN-input combinational block,
//               samples its output and checks it against a latched truth table.
// Revision    : 1.0 - initial release
// ============================================================================
module truth_table_sweeper
    import tts_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [num_vec(N_IN)-1:0]  exp_table,
    input  logic                      dut_f,
    output logic [N_IN-1:0]           stim,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [N_IN:0]             err_count,
    output logic [N_IN-1:0]           first_err_idx,
    output logic [num_vec(N_IN)-1:0]  captured
);

    localparam int c_NUM_VEC = num_vec(N_IN);

    logic [1:0]           r_state;
    logic [N_IN-1:0]      r_stim;
    logic [c_NUM_VEC-1:0] r_table;
    logic [c_NUM_VEC-1:0] r_captured;
    logic [N_IN:0]        r_err_count;
    logic [N_IN-1:0]      r_first_err;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_pass;

    logic                 w_tc;
    logic                 w_load;
    logic                 w_last;
    logic                 w_mismatch;
    logic [N_IN:0]        w_err_inc;
    logic [N_IN:0]        w_err_next;

    // Case inequality so an unknown DUT output is never taken as a match.
    assign w_mismatch = (dut_f !== r_table[r_stim]);
    assign w_last     = (r_stim == '1);
    assign w_err_inc  = r_err_count + (N_IN + 1)'(1);
    assign w_err_next = w_mismatch ? w_err_inc : r_err_count;
    assign w_load     = ((r_state == S_IDLE) && start) ||
                        ((r_state == S_DRIVE) && w_tc && !w_last);

    tts_settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .clk  (clk),
        .rst  (rst),
        .load (w_load),
        .tc   (w_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_stim      <= '0;
            r_table     <= '0;
            r_captured  <= '0;
            r_err_count <= '0;
            r_first_err <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_table     <= exp_table;
                        r_captured  <= '0;
                        r_err_count <= '0;
                        r_first_err <= '0;
                        r_pass      <= 1'b0;
                        r_stim      <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (w_tc) begin
                        r_captured[r_stim] <= dut_f;
                        if (w_mismatch) begin
                            r_err_count <= w_err_inc;
                            if (r_err_count == '0) r_first_err <= r_stim;
                        end
                        if (w_last) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_pass  <= (w_err_next == '0);
                        end else begin
                            r_stim <= r_stim + N_IN'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign stim          = r_stim;
    assign busy          = r_busy;
    assign done          = r_done;
    assign pass          = r_pass;
    assign err_count     = r_err_count;
    assign first_err_idx = r_first_err;
    assign captured      = r_captured;

endmodule
`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : tb_truth_table_sweeper
// Description : Directed bench for the sweeper: a 4-input AND-OR target with
//               SETTLE=1 and a 2-input XOR target with SETTLE=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_truth_table_sweeper;

    logic        clk;
    logic        rst;

    logic        start4;
    logic [15:0] tab4;
    logic        stuck;
    logic        f4;
    logic [3:0]  stim4;
    logic        busy4, done4, pass4;
    logic [4:0]  err4;
    logic [3:0]  first4;
    logic [15:0] cap4;

    logic        start2;
    logic [3:0]  tab2;
    logic        f2;
    logic [1:0]  stim2;
    logic        busy2, done2, pass2;
    logic [2:0]  err2;
    logic [1:0]  first2;
    logic [3:0]  cap2;

    int total = 0;
    int bad   = 0;

    // Targets: F = A&B | C&D (A = stim MSB) with optional stuck-at-0, and F = A^B.
    assign f4 = stuck ? 1'b0 : ((stim4[3] & stim4[2]) | (stim4[1] & stim4[0]));
    assign f2 = stim2[1] ^ stim2[0];

    truth_table_sweeper #(.N_IN(4), .SETTLE(1)) u_dut4 (
        .clk           (clk),
        .rst           (rst),
        .start         (start4),
        .exp_table     (tab4),
        .dut_f         (f4),
        .stim          (stim4),
        .busy          (busy4),
        .done          (done4),
        .pass          (pass4),
        .err_count     (err4),
        .first_err_idx (first4),
        .captured      (cap4)
    );

    truth_table_sweeper #(.N_IN(2), .SETTLE(3)) u_dut2 (
        .clk           (clk),
        .rst           (rst),
        .start         (start2),
        .exp_table     (tab2),
        .dut_f         (f2),
        .stim          (stim2),
        .busy          (busy2),
        .done          (done2),
        .pass          (pass2),
        .err_count     (err2),
        .first_err_idx (first2),
        .captured      (cap2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] table_v;
        bit          stuck_v;
        bit          poke;
        logic        exp_pass;
        logic [4:0]  exp_err;
        logic [3:0]  exp_first;
        logic [15:0] exp_cap;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Starts a 4-input sweep, scrambles exp_table after the start edge, follows
    // the stimulus each cycle and returns the number of edges until done.
    task automatic sweep4(input logic [15:0] t, input bit stuck_i, input bit poke, output int cyc);
        stuck = stuck_i;
        @(negedge clk);
        start4 = 1'b1;
        tab4   = t;
        @(negedge clk);
        start4 = 1'b0;
        tab4   = ~t;
        check("busy_after_start", 32'(busy4), 32'd1);
        cyc = 0;
        while (!done4 && cyc < 100) begin
            check("stim_seq4", 32'(stim4), (cyc > 15) ? 32'd15 : 32'(cyc));
            start4 = (poke && cyc == 7);
            @(negedge clk);
            cyc++;
        end
        start4 = 1'b0;
    endtask

    initial begin
        int cyc;
        int n;
        bit saw_done;

        vecs[0] = '{16'hF888, 1'b0, 1'b0, 1'b1, 5'd0,  4'd0,  16'hF888};
        vecs[1] = '{16'hF889, 1'b0, 1'b1, 1'b0, 5'd1,  4'd0,  16'hF888};
        vecs[2] = '{16'h7888, 1'b0, 1'b0, 1'b0, 5'd1,  4'd15, 16'hF888};
        vecs[3] = '{16'hFFFF, 1'b1, 1'b0, 1'b0, 5'd16, 4'd0,  16'h0000};
        vecs[4] = '{16'h0000, 1'b0, 1'b0, 1'b0, 5'd7,  4'd3,  16'hF888};
        vecs[5] = '{16'h0888, 1'b0, 1'b1, 1'b0, 5'd4,  4'd12, 16'hF888};

        rst    = 1'b1;
        start4 = 1'b0;
        start2 = 1'b0;
        tab4   = 16'hA5A5;
        tab2   = 4'h0;
        stuck  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_stim",  32'(stim4),  32'd0);
        check("rst_busy",  32'(busy4),  32'd0);
        check("rst_done",  32'(done4),  32'd0);
        check("rst_pass",  32'(pass4),  32'd0);
        check("rst_err",   32'(err4),   32'd0);
        check("rst_first", 32'(first4), 32'd0);
        check("rst_cap",   32'(cap4),   32'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            sweep4(vecs[i].table_v, vecs[i].stuck_v, vecs[i].poke, cyc);
            check("done_latency4", 32'(cyc), 32'd16);
            check("done_busy_low", 32'(busy4), 32'd0);
            check("pass4",  32'(pass4),  32'(vecs[i].exp_pass));
            check("err4",   32'(err4),   32'(vecs[i].exp_err));
            check("first4", 32'(first4), 32'(vecs[i].exp_first));
            check("cap4",   32'(cap4),   32'(vecs[i].exp_cap));
            start4 = vecs[i].poke;
            @(negedge clk);
            start4 = 1'b0;
            check("done_pulse_end", 32'(done4), 32'd0);
            @(negedge clk);
            check("idle_busy", 32'(busy4), 32'd0);
            check("held_err",  32'(err4),  32'(vecs[i].exp_err));
            check("held_pass", 32'(pass4), 32'(vecs[i].exp_pass));
            check("held_stim", 32'(stim4), 32'd15);
        end
        stuck = 1'b0;

        // Reset in the cycle stim==5 aborts the sweep with no done pulse.
        @(negedge clk);
        start4 = 1'b1;
        tab4   = 16'hF888;
        @(negedge clk);
        start4 = 1'b0;
        n = 0;
        while (stim4 != 4'd5 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("reach_stim5", 32'(stim4), 32'd5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_stim",  32'(stim4),  32'd0);
        check("abort_busy",  32'(busy4),  32'd0);
        check("abort_done",  32'(done4),  32'd0);
        check("abort_err",   32'(err4),   32'd0);
        check("abort_cap",   32'(cap4),   32'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done4 || busy4) saw_done = 1'b1;
        end
        check("no_done_after_abort", 32'(saw_done), 32'd0);
        sweep4(16'hF888, 1'b0, 1'b0, cyc);
        check("post_abort_latency", 32'(cyc), 32'd16);
        check("post_abort_pass",    32'(pass4), 32'd1);
        check("post_abort_cap",     32'(cap4),  32'hF888);

        // SETTLE=3, two inputs: each vector held three cycles.
        @(negedge clk);
        start2 = 1'b1;
        tab2   = 4'h6;
        @(negedge clk);
        start2 = 1'b0;
        tab2   = 4'h9;
        cyc = 0;
        while (!done2 && cyc < 100) begin
            check("stim_seq2", 32'(stim2), (cyc / 3 > 3) ? 32'd3 : 32'(cyc / 3));
            @(negedge clk);
            cyc++;
        end
        check("done_latency2", 32'(cyc),   32'd12);
        check("stim2_at_done", 32'(stim2), 32'd3);
        check("pass2",         32'(pass2), 32'd1);
        check("err2",          32'(err2),  32'd0);
        check("cap2",          32'(cap2),  32'h6);
        @(negedge clk);
        check("done2_pulse_end", 32'(done2), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
